// File: rtl/can_pkg.sv
`default_nettype none
// ============================================================================
// Module   : can_pkg
// Brief    : Shared CAN frame definitions (field states, widths, CRC-15 poly).
// Revision : 1.0
// ============================================================================
package can_pkg;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_START,
        ST_SOF,
        ST_ID_A,
        ST_SRR,
        ST_IDE,
        ST_ID_B,
        ST_RTR,
        ST_R1,
        ST_R0,
        ST_DLC,
        ST_DATA,
        ST_CRC,
        ST_CRC_DEL,
        ST_ACK_SLOT,
        ST_ACK_DEL,
        ST_EOF,
        ST_IFS
    } can_state_e;

    localparam logic [14:0] CRC_POLY    = 15'h4599;
    localparam int          STUFF_LIMIT = 5;
    localparam int          ID_A_W      = 11;
    localparam int          ID_B_W      = 18;
    localparam int          DLC_W       = 4;
    localparam int          DATA_W      = 64;
    localparam int          CRC_W       = 15;

    // A DLC above 8 still carries only 8 bytes; remote frames carry none.
    function automatic logic [6:0] data_bit_count(input logic [3:0] dlc, input logic rtr);
        if (rtr) begin
            return 7'd0;
        end else if (dlc > 4'd8) begin
            return 7'd64;
        end else begin
            return {dlc, 3'b000};
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/can_crc15.sv
`default_nettype none
// ============================================================================
// Module   : can_crc15
// Brief    : Serial CAN CRC-15 register with synchronous clear and bit enable.
// Revision : 1.0
// ============================================================================
module can_crc15
    import can_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic             w_fb;
    logic [CRC_W-1:0] w_shift;

    assign w_fb    = bit_in ^ crc[CRC_W-1];
    assign w_shift = {crc[CRC_W-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= w_fb ? (w_shift ^ CRC_POLY) : w_shift;
        end
    end

endmodule
`default_nettype wire

// File: rtl/can_encoder.sv
`default_nettype none
// ============================================================================
// Module   : can_encoder
// Brief    : CAN 2.0A/B frame transmitter with stuffing, CRC-15, arbitration
//            and ACK-slot checking; one bit per sample_point rising edge.
// Revision : 1.0
// ============================================================================
module can_encoder
    import can_pkg::*;
#(
    parameter int IFS_BITS = 3,
    parameter int EOF_BITS = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_point,
    input  logic              rx_bit,
    input  logic              tx_req,
    input  logic [ID_A_W-1:0] field_id_a,
    input  logic              field_ide,
    input  logic              field_rtr,
    input  logic [ID_B_W-1:0] field_id_b,
    input  logic [DLC_W-1:0]  field_dlc,
    input  logic [DATA_W-1:0] field_data,
    output logic              tx_bit,
    output logic              busy,
    output logic              done,
    output logic              arb_lost,
    output logic              ack_error,
    output logic [CRC_W-1:0]  crc_out
);

    can_state_e        r_state;
    logic [5:0]        r_cnt;
    logic [2:0]        r_run;
    logic              r_sp_prev;
    logic [ID_A_W-1:0] r_id_a;
    logic              r_ide;
    logic              r_rtr;
    logic [ID_B_W-1:0] r_id_b;
    logic [DLC_W-1:0]  r_dlc;
    logic [DATA_W-1:0] r_data;
    logic [6:0]        r_ndata;

    can_state_e        w_state_nxt;
    can_state_e        w_adv_state;
    logic [5:0]        w_cnt_nxt;
    logic [5:0]        w_adv_cnt;
    logic [5:0]        w_data_idx;
    logic [2:0]        w_run_nxt;
    logic              w_adv_bit;
    logic              w_tx_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_arb_nxt;
    logic              w_ack_nxt;
    logic [CRC_W-1:0]  w_crc_out_nxt;
    logic [CRC_W-1:0]  w_crc;
    logic              w_latch;
    logic              w_crc_clr;
    logic              w_crc_en;
    logic              w_sp_rise;
    logic              w_in_arb;
    logic              w_in_stuff;

    assign w_sp_rise  = sample_point & ~r_sp_prev;
    assign w_in_arb   = r_state inside {ST_ID_A, ST_SRR, ST_IDE, ST_ID_B, ST_RTR};
    assign w_in_stuff = (r_state >= ST_SOF) && (r_state <= ST_CRC);
    // Data is sent MSB first from bit 63; counter runs n-1..0, so wrap-subtract.
    assign w_data_idx = w_adv_cnt - r_ndata[5:0];

    can_crc15 u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_crc_clr),
        .en     (w_crc_en),
        .bit_in (w_adv_bit),
        .crc    (w_crc)
    );

    // Field position of the next unstuffed bit.
    always_comb begin
        w_adv_state = r_state;
        w_adv_cnt   = r_cnt - 6'd1;
        if (r_cnt == 6'd0) begin
            w_adv_cnt = '0;
            case (r_state)
                ST_START:    w_adv_state = ST_SOF;
                ST_SOF: begin
                    w_adv_state = ST_ID_A;
                    w_adv_cnt   = 6'(ID_A_W - 1);
                end
                ST_ID_A:     w_adv_state = r_ide ? ST_SRR : ST_RTR;
                ST_SRR:      w_adv_state = ST_IDE;
                ST_IDE: begin
                    if (r_ide) begin
                        w_adv_state = ST_ID_B;
                        w_adv_cnt   = 6'(ID_B_W - 1);
                    end else begin
                        w_adv_state = ST_R0;
                    end
                end
                ST_ID_B:     w_adv_state = ST_RTR;
                ST_RTR:      w_adv_state = r_ide ? ST_R1 : ST_IDE;
                ST_R1:       w_adv_state = ST_R0;
                ST_R0: begin
                    w_adv_state = ST_DLC;
                    w_adv_cnt   = 6'(DLC_W - 1);
                end
                ST_DLC: begin
                    if (r_ndata == 7'd0) begin
                        w_adv_state = ST_CRC;
                        w_adv_cnt   = 6'(CRC_W - 1);
                    end else begin
                        w_adv_state = ST_DATA;
                        w_adv_cnt   = 6'(r_ndata - 7'd1);
                    end
                end
                ST_DATA: begin
                    w_adv_state = ST_CRC;
                    w_adv_cnt   = 6'(CRC_W - 1);
                end
                ST_CRC:      w_adv_state = ST_CRC_DEL;
                ST_CRC_DEL:  w_adv_state = ST_ACK_SLOT;
                ST_ACK_SLOT: w_adv_state = ST_ACK_DEL;
                ST_ACK_DEL: begin
                    w_adv_state = ST_EOF;
                    w_adv_cnt   = 6'(EOF_BITS - 1);
                end
                ST_EOF: begin
                    w_adv_state = ST_IFS;
                    w_adv_cnt   = 6'(IFS_BITS - 1);
                end
                default:     w_adv_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_adv_bit = 1'b1;
        case (w_adv_state)
            ST_SOF, ST_R1, ST_R0: w_adv_bit = 1'b0;
            ST_ID_A:              w_adv_bit = r_id_a[w_adv_cnt[3:0]];
            ST_IDE:               w_adv_bit = r_ide;
            ST_ID_B:              w_adv_bit = r_id_b[w_adv_cnt[4:0]];
            ST_RTR:               w_adv_bit = r_rtr;
            ST_DLC:               w_adv_bit = r_dlc[w_adv_cnt[1:0]];
            ST_DATA:              w_adv_bit = r_data[w_data_idx];
            ST_CRC:               w_adv_bit = w_crc[w_adv_cnt[3:0]];
            default:              w_adv_bit = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_run_nxt     = r_run;
        w_tx_nxt      = tx_bit;
        w_busy_nxt    = busy;
        w_done_nxt    = 1'b0;
        w_arb_nxt     = 1'b0;
        w_ack_nxt     = 1'b0;
        w_crc_out_nxt = crc_out;
        w_latch       = 1'b0;
        w_crc_clr     = 1'b0;
        w_crc_en      = 1'b0;
        if (r_state == ST_IDLE) begin
            if (tx_req) begin
                w_latch     = 1'b1;
                w_crc_clr   = 1'b1;
                w_state_nxt = ST_START;
                w_cnt_nxt   = '0;
                w_busy_nxt  = 1'b1;
            end
        end else if (w_sp_rise) begin
            if (w_in_arb && tx_bit && !rx_bit) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
                w_arb_nxt   = 1'b1;
            end else if (w_in_stuff && (r_run == 3'(STUFF_LIMIT))) begin
                // Stuff bit: field position holds, run restarts with it.
                w_tx_nxt  = ~tx_bit;
                w_run_nxt = 3'd1;
            end else begin
                w_state_nxt = w_adv_state;
                w_cnt_nxt   = w_adv_cnt;
                w_tx_nxt    = w_adv_bit;
                if (w_adv_bit != tx_bit) begin
                    w_run_nxt = 3'd1;
                end else if (r_run != 3'd7) begin
                    w_run_nxt = r_run + 3'd1;
                end
                w_crc_en = (w_adv_state >= ST_SOF) && (w_adv_state <= ST_DATA);
                if ((r_state == ST_ACK_SLOT) && rx_bit) begin
                    w_ack_nxt = 1'b1;
                end
                if ((w_adv_state == ST_CRC) && (r_state != ST_CRC)) begin
                    w_crc_out_nxt = w_crc;
                end
                if (w_adv_state == ST_IDLE) begin
                    w_done_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_run     <= '0;
            r_sp_prev <= 1'b0;
            r_id_a    <= '0;
            r_ide     <= 1'b0;
            r_rtr     <= 1'b0;
            r_id_b    <= '0;
            r_dlc     <= '0;
            r_data    <= '0;
            r_ndata   <= '0;
            tx_bit    <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            arb_lost  <= 1'b0;
            ack_error <= 1'b0;
            crc_out   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_run     <= w_run_nxt;
            r_sp_prev <= sample_point;
            tx_bit    <= w_tx_nxt;
            busy      <= w_busy_nxt;
            done      <= w_done_nxt;
            arb_lost  <= w_arb_nxt;
            ack_error <= w_ack_nxt;
            crc_out   <= w_crc_out_nxt;
            if (w_latch) begin
                r_id_a  <= field_id_a;
                r_ide   <= field_ide;
                r_rtr   <= field_rtr;
                r_id_b  <= field_id_b;
                r_dlc   <= field_dlc;
                r_data  <= field_data;
                r_ndata <= data_bit_count(field_dlc, field_rtr);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_can_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_encoder
// Brief    : Directed and random frames checked against a bit-list frame model.
// Revision : 1.0
// ============================================================================
module tb_can_encoder;

    localparam int IFS_BITS = 3;
    localparam int EOF_BITS = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_point = 1'b0;
    logic        rx_bit = 1'b1;
    logic        tx_req = 1'b0;
    logic [10:0] field_id_a = '0;
    logic        field_ide = 1'b0;
    logic        field_rtr = 1'b0;
    logic [17:0] field_id_b = '0;
    logic [3:0]  field_dlc = '0;
    logic [63:0] field_data = '0;
    logic        tx_bit;
    logic        busy;
    logic        done;
    logic        arb_lost;
    logic        ack_error;
    logic [14:0] crc_out;

    int          checks = 0;
    int          errors = 0;
    int          n_done = 0;
    int          n_arb  = 0;
    int          n_ack  = 0;
    bit          exp_q[$];
    bit          got_q[$];
    int          ack_idx;
    logic [14:0] exp_crc;

    can_encoder #(.IFS_BITS(IFS_BITS), .EOF_BITS(EOF_BITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_point (sample_point),
        .rx_bit       (rx_bit),
        .tx_req       (tx_req),
        .field_id_a   (field_id_a),
        .field_ide    (field_ide),
        .field_rtr    (field_rtr),
        .field_id_b   (field_id_b),
        .field_dlc    (field_dlc),
        .field_data   (field_data),
        .tx_bit       (tx_bit),
        .busy         (busy),
        .done         (done),
        .arb_lost     (arb_lost),
        .ack_error    (ack_error),
        .crc_out      (crc_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1)      n_done++;
        if (arb_lost === 1'b1)  n_arb++;
        if (ack_error === 1'b1) n_ack++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sp_tick(input int hold);
        @(negedge clk) sample_point = 1'b1;
        repeat (hold) @(negedge clk);
        sample_point = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Whole frame as a bus bit list: fields, CRC by polynomial long division,
    // stuffing over SOF..CRC, then fixed recessive tail.
    task automatic build_frame(input logic [10:0] a, input logic ide, input logic rtr,
                               input logic [17:0] b, input logic [3:0] dlc, input logic [63:0] d);
        bit          raw[$];
        bit          div[$];
        logic [15:0] gpoly;
        int          nbits;
        int          raw_len;
        int          run;
        bit          last;
        gpoly = 16'hC599;
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(a[i]);
        if (ide) begin
            raw.push_back(1'b1);
            raw.push_back(1'b1);
            for (int i = 17; i >= 0; i--) raw.push_back(b[i]);
            raw.push_back(rtr);
            raw.push_back(1'b0);
            raw.push_back(1'b0);
        end else begin
            raw.push_back(rtr);
            raw.push_back(1'b0);
            raw.push_back(1'b0);
        end
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nbits = rtr ? 0 : 8 * ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int k = 0; k < nbits; k++) raw.push_back(d[63 - k]);
        raw_len = raw.size();
        div = raw;
        for (int i = 0; i < 15; i++) div.push_back(1'b0);
        for (int i = 0; i < raw_len; i++) begin
            if (div[i]) begin
                for (int j = 0; j < 16; j++) div[i + j] = div[i + j] ^ gpoly[15 - j];
            end
        end
        for (int j = 0; j < 15; j++) exp_crc[14 - j] = div[raw_len + j];
        for (int j = 14; j >= 0; j--) raw.push_back(exp_crc[j]);
        exp_q = {};
        run   = 0;
        last  = 1'b1;
        foreach (raw[i]) begin
            exp_q.push_back(raw[i]);
            run  = (raw[i] == last) ? run + 1 : 1;
            last = raw[i];
            if (run == 5) begin
                exp_q.push_back(~raw[i]);
                last = ~raw[i];
                run  = 1;
            end
        end
        exp_q.push_back(1'b1);
        ack_idx = exp_q.size();
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        for (int i = 0; i < EOF_BITS + IFS_BITS; i++) exp_q.push_back(1'b1);
    endtask

    task automatic start_frame(input logic [10:0] a, input logic ide, input logic rtr,
                               input logic [17:0] b, input logic [3:0] dlc, input logic [63:0] d);
        field_id_a = a;
        field_ide  = ide;
        field_rtr  = rtr;
        field_id_b = b;
        field_dlc  = dlc;
        field_data = d;
        @(negedge clk) tx_req = 1'b1;
        @(negedge clk) tx_req = 1'b0;
        chk("busy_accept", 64'(busy), 64'd1);
        // Inputs are latched; scrambling them must not disturb the frame.
        field_id_a = ~a;
        field_data = {$urandom, $urandom};
        got_q = {};
    endtask

    task automatic run_bits(input int first, input int last, input bit ack_missing);
        for (int k = first; k <= last; k++) begin
            rx_bit = (k == 0) ? 1'b1 : ((k - 1 == ack_idx) ? ack_missing : exp_q[k - 1]);
            sp_tick(int'($urandom_range(1, 3)));
            got_q.push_back(tx_bit);
            chk($sformatf("tx_bit[%0d]", k), 64'(tx_bit), 64'(exp_q[k]));
        end
    endtask

    task automatic run_frame(input logic [10:0] a, input logic ide, input logic rtr,
                             input logic [17:0] b, input logic [3:0] dlc, input logic [63:0] d,
                             input bit ack_missing);
        int d0;
        int k0;
        build_frame(a, ide, rtr, b, dlc, d);
        d0 = n_done;
        k0 = n_ack;
        start_frame(a, ide, rtr, b, dlc, d);
        run_bits(0, exp_q.size() - 1, ack_missing);
        chk("done_before_end", 64'(n_done - d0), 64'd0);
        rx_bit = 1'b1;
        sp_tick(1);
        chk("done_pulse", 64'(n_done - d0), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
        chk("ack_error_count", 64'(n_ack - k0), 64'(ack_missing));
        chk("crc_out", 64'(crc_out), 64'(exp_crc));
    endtask

    initial begin
        logic [20:0] f21_exp;
        logic [20:0] f21_got;
        int          d0;
        int          a0;

        repeat (3) @(negedge clk);
        chk("rst_tx_bit", 64'(tx_bit), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_arb_lost", 64'(arb_lost), 64'd0);
        chk("rst_ack_error", 64'(ack_error), 64'd0);
        chk("rst_crc_out", 64'(crc_out), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Standard frame, ID 0x014, one data byte 0x01
        run_frame(11'h014, 1'b0, 1'b0, 18'h0, 4'd1, 64'h0100_0000_0000_0000, 1'b0);
        f21_exp = 21'b000001001010000010001;
        for (int i = 0; i < 21; i++) f21_got[20 - i] = got_q[i];
        chk("first21_bits", 64'(f21_got), 64'(f21_exp));

        // Extended remote frame, all-ones identifiers
        run_frame(11'h7FF, 1'b1, 1'b1, 18'h3FFFF, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        // Missing ACK
        run_frame(11'h123, 1'b0, 1'b0, 18'h0, 4'd2, 64'hA55A_0000_0000_0000, 1'b1);

        // DLC above 8 carries 8 bytes
        run_frame(11'h3C5, 1'b0, 1'b0, 18'h0, 4'd15, 64'h0123_4567_89AB_CDEF, 1'b0);

        // Arbitration loss at ID_A bit 3 (bus index 8, recessive)
        build_frame(11'h2AA, 1'b0, 1'b0, 18'h0, 4'd2, 64'h1234_0000_0000_0000);
        d0 = n_done;
        a0 = n_arb;
        start_frame(11'h2AA, 1'b0, 1'b0, 18'h0, 4'd2, 64'h1234_0000_0000_0000);
        run_bits(0, 8, 1'b0);
        rx_bit = 1'b0;
        sp_tick(1);
        chk("arb_lost_pulse", 64'(n_arb - a0), 64'd1);
        chk("arb_tx_bit", 64'(tx_bit), 64'd1);
        chk("arb_busy", 64'(busy), 64'd0);
        rx_bit = 1'b1;
        repeat (10) sp_tick(1);
        chk("arb_tx_idle", 64'(tx_bit), 64'd1);
        chk("arb_no_done", 64'(n_done - d0), 64'd0);
        chk("arb_single", 64'(n_arb - a0), 64'd1);

        // Fresh frame after arbitration loss
        run_frame(11'h2AA, 1'b0, 1'b0, 18'h0, 4'd2, 64'h1234_0000_0000_0000, 1'b0);

        // Reset in the middle of DATA
        build_frame(11'h014, 1'b0, 1'b0, 18'h0, 4'd1, 64'h0100_0000_0000_0000);
        d0 = n_done;
        start_frame(11'h014, 1'b0, 1'b0, 18'h0, 4'd1, 64'h0100_0000_0000_0000);
        run_bits(0, 23, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        chk("midrst_tx_bit", 64'(tx_bit), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_crc_out", 64'(crc_out), 64'd0);
        rx_bit = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sp_tick(1);
            chk("midrst_idle_tx", 64'(tx_bit), 64'd1);
        end
        chk("midrst_no_done", 64'(n_done - d0), 64'd0);

        // Random frames
        for (int i = 0; i < 6; i++) begin
            run_frame(11'($urandom), 1'($urandom), 1'($urandom), 18'($urandom),
                      4'($urandom), {$urandom, $urandom}, (i == 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/can_encoder.md
Name: can_encoder

Overview:
- CAN 2.0A/2.0B frame transmitter; transmit-side counterpart of can_decoder.
- Latches frame fields on a request, then serializes one bit per sample_point rising edge: SOF through IFS, with bit stuffing, CRC-15 generation, arbitration-loss detection and ACK-slot check.
- Sits between the host/controller register interface and the bus transceiver TX line; rx_bit is the bus readback.

Parameters:
- IFS_BITS, 3, number of recessive intermission bits sent after EOF before done.
- EOF_BITS, 7, number of recessive end-of-frame bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- sample_point  in  1  bit-timing strobe; its rising edge (0 then 1 on consecutive clk samples) is the bit boundary.
- rx_bit  in  1  bus level read back at the sample point.
- tx_req  in  1  request to send; honoured only in IDLE.
- field_id_a  in  11  base identifier, MSB first.
- field_ide  in  1  1 = extended frame.
- field_rtr  in  1  1 = remote frame (no data field).
- field_id_b  in  18  extended identifier, used when field_ide = 1.
- field_dlc  in  4  data length code.
- field_data  in  64  payload; byte 0 is field_data[63:56], sent MSB first.
- tx_bit  out  1  registered bus output; 1 = recessive.
- busy  out  1  high from request acceptance until done.
- done  out  1  one-cycle pulse when IFS completes.
- arb_lost  out  1  one-cycle pulse when arbitration is lost.
- ack_error  out  1  one-cycle pulse when the ACK slot is read recessive.
- crc_out  out  15  CRC of the current or last frame, valid from CRC state onward.

Behaviour:
- Reset (rst = 0 at a clk edge):
  - tx_bit = 1; busy, done, arb_lost and ack_error = 0; crc_out = 0.
  - State goes to IDLE and the edge detector clears.
  - Reset mid-frame aborts the frame at the next clk edge.
- Bit edge (sp_rise): sample_point = 1 and the registered previous value = 0.
  - All bit-level actions occur on the clk cycle where sp_rise is true.
  - tx_bit for the next bit is registered in that same cycle, so it changes one clk after sp_rise.
  - The bus value therefore stays stable across the following sample point.
- Request acceptance:
  - IDLE with tx_req = 1 latches all field_* inputs and sets busy.
  - On the next sp_rise, SOF (0) is driven.
  - tx_req is ignored while busy.
- State sequence, standard frame: SOF, ID_A(11), RTR, IDE(0), R0(0), DLC(4), DATA, CRC(15), CRC_DEL(1), ACK_SLOT(1), ACK_DEL(1), EOF(EOF_BITS x 1), IFS(IFS_BITS x 1), IDLE.
- State sequence, extended frame: SOF, ID_A, SRR(1), IDE(1), ID_B(18), RTR, R1(0), R0(0), DLC, DATA, then as for the standard frame.
- DATA length: 8*min(dlc,8) bits; 0 bits if rtr = 1. A dlc above 8 is sent unchanged but carries 8 bytes.
- A 6-bit down-counter indexes bits within each field.
- Stuffing, SOF through the last CRC bit:
  - After 5 consecutive equal transmitted bits, insert the complement.
  - Stuff bits count as the first bit of the new run.
  - If the 5th equal bit is the last CRC bit, the stuff bit is still inserted before CRC_DEL.
  - No stuffing from CRC_DEL onward.
- CRC-15 (polynomial 0x4599, init 0):
  - Computed over unstuffed bits from SOF through the last DATA bit.
  - Frozen into crc_out on entry to CRC; sent MSB first.
- Arbitration field (ID_A, SRR, IDE, ID_B, RTR): if tx_bit = 1 and rx_bit = 0 at sp_rise, then:
  - arb_lost pulses;
  - tx_bit = 1 and busy = 0;
  - state returns to IDLE; done is not pulsed.
- ACK_SLOT:
  - tx_bit = 1; rx_bit is checked at the sp_rise that ends the slot.
  - If rx_bit = 1, ack_error pulses and the frame continues to completion.
- done pulses in the cycle the last IFS bit ends; busy falls in the same cycle.
- tx_req high on that same cycle is accepted on the next clk only.
- sample_point held high continuously produces no further edges, and the bit does not advance.

Decomposition:
- Shared package can_pkg:
  - state enum;
  - CRC_POLY = 15'h4599;
  - STUFF_LIMIT = 5;
  - field widths.
- can_pkg is reused by can_decoder.
- One sub-module: can_crc15, a serial CRC register with clear, enable and bit-in ports.
- Stuffing and sequencing stay in can_encoder.

Test Plan:
- Standard frame, ID 0x014, rtr 0, dlc 1, data byte 0x01:
  - First 21 bus bits are 000001001010000010001, with stuff bits at positions 5 and 16.
  - Looped into can_decoder, it returns the same id/dlc/data, and field_crc equals crc_out.
  - Ends with 10 recessive bits (1 + 1 + 1 + 7), then 3 IFS bits, then a single done pulse.
- Extended frame, ID_A 0x7FF, ID_B 0x3FFFF, rtr 1:
  - Recessive runs are stuffed with 0 after every 5 ones.
  - No DATA bits are sent.
  - Decoder field_srr = 1 and field_ide = 1.
- Arbitration loss: rx_bit forced to 0 while tx_bit = 1 at ID_A bit 3:
  - arb_lost pulses once; tx_bit stays 1; busy drops.
  - No done pulse; the next tx_req starts a fresh SOF.
- ACK missing: rx_bit follows tx_bit except ACK_SLOT, which reads 1:
  - ack_error pulses once; EOF and IFS still complete; done pulses.
- Reset mid-DATA: rst = 0 for one clk:
  - tx_bit = 1 and busy = 0 on the next clk; further sample points produce no output change.
- dlc 15, data 0x0123456789ABCDEF:
  - Exactly 64 data bits are sent.
  - CRC matches the golden model computed with DLC field 1111.
